// File: rtl/rv_decode_pkg.sv
// Shared types and encodings for the RV32I/RV64I decode stage.
// Op codes, opcode/funct localparams, immediate formats and the decoded-entry payload.
package rv_decode_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [OP_W-1:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    op_e              op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I/RV64I (+optional M) decoder: instruction word to
// op, register indices, sign-extended immediate and illegal flag.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic [31:0]     instr_i,
  output dec_t            dec_c,
  output logic [XLEN-1:0] imm_c
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [5:0]         shamt;
  logic               shift_base_ok;
  logic               shift_alt_ok;
  logic               is_shift;
  logic               illegal;
  op_e                op;
  fmt_e               fmt;
  logic signed [31:0] imm_s;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // RV64 widens shamt to 6 bits, so only funct6 qualifies the shift kind
  assign shift_base_ok = (XLEN == 64) ? (instr_i[31:26] == 6'b000000) : (funct7 == F7_BASE);
  assign shift_alt_ok  = (XLEN == 64) ? (instr_i[31:26] == 6'b010000) : (funct7 == F7_ALT);
  assign shamt         = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

  // Opcode/funct decode; anything not matched stays OP_ILLEGAL
  always_comb begin
    op       = OP_ILLEGAL;
    fmt      = FMT_R;
    is_shift = 1'b0;
    case (opcode)
      OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; end
      OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; end
      OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; end
      OPC_JALR: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) op = OP_JALR;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        case (funct3)
          F3_ADD_SUB: op = OP_ADDI;
          F3_SLT:     op = OP_SLTI;
          F3_SLTU:    op = OP_SLTIU;
          F3_XOR:     op = OP_XORI;
          F3_OR:      op = OP_ORI;
          F3_AND:     op = OP_ANDI;
          F3_SLL: begin
            is_shift = 1'b1;
            if (shift_base_ok) op = OP_SLLI;
          end
          F3_SR: begin
            is_shift = 1'b1;
            if (shift_base_ok)     op = OP_SRLI;
            else if (shift_alt_ok) op = OP_SRAI;
          end
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        fmt = FMT_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: op = OP_ADD;
            F3_SLL:     op = OP_SLL;
            F3_SLT:     op = OP_SLT;
            F3_SLTU:    op = OP_SLTU;
            F3_XOR:     op = OP_XOR;
            F3_SR:      op = OP_SRL;
            F3_OR:      op = OP_OR;
            default:    op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD_SUB)  op = OP_SUB;
          else if (funct3 == F3_SR)  op = OP_SRA;
        end else if (funct7 == F7_MULDIV && ENABLE_M) begin
          case (funct3)
            3'b000:  op = OP_MUL;
            3'b001:  op = OP_MULH;
            3'b010:  op = OP_MULHSU;
            3'b011:  op = OP_MULHU;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            default: op = OP_REMU;
          endcase
        end
      end
      OPC_FENCE: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) op = OP_FENCE;
      end
      OPC_SYSTEM: begin
        fmt = FMT_I;
        if (instr_i == INSTR_ECALL)       op = OP_ECALL;
        else if (instr_i == INSTR_EBREAK) op = OP_EBREAK;
      end
      default: op = OP_ILLEGAL;
    endcase
  end

  // Raw 32-bit immediate per format, sign bit always instr[31]
  always_comb begin
    imm_s = '0;
    case (fmt)
      FMT_I:   imm_s = 32'($signed(instr_i[31:20]));
      FMT_S:   imm_s = 32'($signed({instr_i[31:25], instr_i[11:7]}));
      FMT_B:   imm_s = 32'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
      FMT_U:   imm_s = {instr_i[31:12], 12'b0};
      FMT_J:   imm_s = 32'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
      default: imm_s = '0;
    endcase
  end

  assign illegal = (op == OP_ILLEGAL);

  always_comb begin
    dec_c = '0;
    imm_c = '0;
    if (illegal) begin
      dec_c.op      = OP_ILLEGAL;
      dec_c.illegal = 1'b1;
    end else begin
      dec_c.op  = op;
      dec_c.rd  = ((fmt inside {FMT_B, FMT_S}) || (op inside {OP_FENCE, OP_ECALL, OP_EBREAK}))
                  ? 5'd0 : instr_i[11:7];
      dec_c.rs1 = (fmt inside {FMT_U, FMT_J}) ? 5'd0 : instr_i[19:15];
      dec_c.rs2 = (fmt inside {FMT_R, FMT_B, FMT_S}) ? instr_i[24:20] : 5'd0;
      imm_c     = is_shift ? XLEN'(shamt) : XLEN'(imm_s);
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode pipeline stage with valid/ready handshakes and a skid entry,
// so in_ready depends only on a flop and full throughput is kept with out_ready=1.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [OP_W-1:0]  out_op,
  output logic [REG_W-1:0] out_rd,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal
);

  dec_t            new_dec;
  logic [XLEN-1:0] new_imm;
  logic            accept;

  logic            main_valid_q, main_valid_d;
  dec_t            main_dec_q,   main_dec_d;
  logic [XLEN-1:0] main_imm_q,   main_imm_d;
  logic [XLEN-1:0] main_pc_q,    main_pc_d;
  logic            skid_valid_q, skid_valid_d;
  dec_t            skid_dec_q,   skid_dec_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic            in_ready_q;

  rv_decode_comb #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr_i (in_instr),
    .dec_c   (new_dec),
    .imm_c   (new_imm)
  );

  assign accept = in_valid && in_ready_q;

  // Skid can only be occupied while main is, and in_ready is low while skid is full,
  // so a drain never has to place a skid entry and a new entry at the same time.
  always_comb begin
    main_valid_d = main_valid_q;
    main_dec_d   = main_dec_q;
    main_imm_d   = main_imm_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_dec_d   = skid_dec_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_dec_d   = skid_dec_q;
        main_imm_d   = skid_imm_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_dec_d = new_dec;
          main_imm_d = new_imm;
          main_pc_d  = in_pc;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_dec_d   = new_dec;
      skid_imm_d   = new_imm;
      skid_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid_q <= 1'b0;
      main_dec_q   <= '0;
      main_imm_q   <= '0;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_dec_q   <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_dec_q   <= main_dec_d;
      main_imm_q   <= main_imm_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_dec_q   <= skid_dec_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_pc      = main_pc_q;
  assign out_op      = main_dec_q.op;
  assign out_rd      = main_dec_q.rd;
  assign out_rs1     = main_dec_q.rs1;
  assign out_rs2     = main_dec_q.rs2;
  assign out_imm     = main_imm_q;
  assign out_illegal = main_dec_q.illegal;

endmodule
